// File: rtl/gcd_job_dispatcher_if.sv
// -----------------------------------------------------------------------------
// gcd_job_dispatcher_if
//   Request/response handshake bundle between a job producer (master) and the
//   GCD job dispatcher (slave).
//
//   Request  : req_valid / req_ready, operands req_a / req_b
//   Response : rsp_valid / rsp_ready, rsp_result, rsp_timeout
//
//   master modport: the producer side (testbench or bus bridge)
//   slave  modport: the dispatcher side
// -----------------------------------------------------------------------------
interface gcd_job_dispatcher_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_timeout;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_timeout
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_timeout
    );
endinterface

// File: rtl/gcd_job_dispatcher.sv
// -----------------------------------------------------------------------------
// gcd_job_dispatcher
//   Initiator side of the GCD engine start/done interface. Operand pairs are
//   accepted on the request handshake, queued in a small FIFO and issued one
//   at a time to the engine. The engine result (or a timeout abort) is handed
//   back on the response handshake, in request order.
//
// Ports
//   clk           in   clock
//   reset_n       in   asynchronous, active-low reset
//   bus           if   request/response handshakes (slave modport)
//   o_gcd_start   out  one-cycle start pulse to the engine
//   o_gcd_a/b     out  operands to the engine, stable until the job ends
//   i_gcd_result  in   engine result
//   i_gcd_done    in   engine result valid
//   o_busy        out  FSM not idle or FIFO not empty
// -----------------------------------------------------------------------------
module gcd_job_dispatcher #(
    parameter int WIDTH      = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    gcd_job_dispatcher_if.slave  bus,
    output logic                 o_gcd_start,
    output logic [WIDTH-1:0]     o_gcd_a,
    output logic [WIDTH-1:0]     o_gcd_b,
    input  logic [WIDTH-1:0]     i_gcd_result,
    input  logic                 i_gcd_done,
    output logic                 o_busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // ---------------------------------------------------------------------
    // Request FIFO. Pointers carry one extra wrap bit so that equal index
    // bits with differing wrap bits means full, fully equal means empty.
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] r_mem_a [FIFO_DEPTH];
    logic [WIDTH-1:0] r_mem_b [FIFO_DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_head_a;
    logic [WIDTH-1:0] w_head_b;

    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                      (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    // Ready depends on full only, so a pop in the same cycle never frees a
    // slot for a simultaneous push.
    assign w_push   = bus.req_valid && !w_full;
    assign w_head_a = r_mem_a[r_rd_ptr[PTR_W-1:0]];
    assign w_head_b = r_mem_b[r_rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr[PTR_W-1:0]] <= bus.req_a;
            r_mem_b[r_wr_ptr[PTR_W-1:0]] <= bus.req_b;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Job FSM
    // ---------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_gcd_a;
    logic [WIDTH-1:0] r_gcd_b;
    logic [WIDTH-1:0] r_rsp_result;
    logic             r_rsp_timeout;

    logic             w_load_ops;
    logic             w_cnt_clr;
    logic             w_cnt_inc;
    logic             w_set_zero;
    logic             w_set_done;
    logic             w_set_to;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load_ops  = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_set_zero  = 1'b0;
        w_set_done  = 1'b0;
        w_set_to    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_load_ops = 1'b1;
                    // gcd(0,x)=x and gcd(0,0)=0: answer directly, engine untouched.
                    if ((w_head_a == '0) || (w_head_b == '0)) begin
                        w_set_zero  = 1'b1;
                        w_state_nxt = S_RESP;
                    end else begin
                        w_state_nxt = S_ISSUE;
                    end
                end
            end

            S_ISSUE: begin
                w_cnt_clr   = 1'b1;
                w_state_nxt = S_WAIT;
            end

            S_WAIT: begin
                w_cnt_inc = 1'b1;
                // r_cnt == 0 marks the first WAIT cycle, where a done left
                // over from the previous job may still be visible. A genuine
                // done beats the timeout when both land in the same cycle.
                if ((r_cnt != '0) && i_gcd_done) begin
                    w_set_done  = 1'b1;
                    w_state_nxt = S_RESP;
                end else if (r_cnt == CNT_LAST) begin
                    w_set_to    = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end

            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath registers: operands, wait counter, response
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_gcd_a       <= '0;
            r_gcd_b       <= '0;
            r_cnt         <= '0;
            r_rsp_result  <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            if (w_load_ops) begin
                r_gcd_a <= w_head_a;
                r_gcd_b <= w_head_b;
            end

            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_set_zero) begin
                r_rsp_result  <= w_head_a | w_head_b;
                r_rsp_timeout <= 1'b0;
            end else if (w_set_done) begin
                r_rsp_result  <= i_gcd_result;
                r_rsp_timeout <= 1'b0;
            end else if (w_set_to) begin
                r_rsp_result  <= '0;
                r_rsp_timeout <= 1'b1;
            end
        end
    end

    assign bus.req_ready   = !w_full;
    assign bus.rsp_valid   = (r_state == S_RESP);
    assign bus.rsp_result  = r_rsp_result;
    assign bus.rsp_timeout = r_rsp_timeout;

    assign o_gcd_start = (r_state == S_ISSUE);
    assign o_gcd_a     = r_gcd_a;
    assign o_gcd_b     = r_gcd_b;
    assign o_busy      = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_gcd_job_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_gcd_job_dispatcher
//   Directed bench for gcd_job_dispatcher (WIDTH=32, FIFO_DEPTH=4, TIMEOUT=16).
//   A behavioural engine answers gcd_start after a programmable latency, can
//   emit a stale done in the first WAIT cycle, or hang on a chosen job.
// -----------------------------------------------------------------------------
module tb_gcd_job_dispatcher;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    gcd_job_dispatcher_if #(.WIDTH(32)) bus();

    logic        gcd_start;
    logic [31:0] gcd_a;
    logic [31:0] gcd_b;
    logic [31:0] gcd_result;
    logic        gcd_done;
    logic        busy;

    gcd_job_dispatcher #(
        .WIDTH      (32),
        .FIFO_DEPTH (4),
        .TIMEOUT    (16)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .o_gcd_start  (gcd_start),
        .o_gcd_a      (gcd_a),
        .o_gcd_b      (gcd_b),
        .i_gcd_result (gcd_result),
        .i_gcd_done   (gcd_done),
        .o_busy       (busy)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- engine model ----------------
    int          eng_lat     = 4;
    bit          eng_stale   = 1'b0;
    int          eng_hang_id = -1;
    bit          eng_run;
    int          eng_cnt;
    logic [31:0] eng_res;

    function automatic logic [31:0] gcd_ref(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // ---------------- monitor (samples mid-low-phase) ----------------
    int          start_cnt = 0;
    int          rsp_n = 0;
    logic [31:0] rsp_res [64];
    logic        rsp_to  [64];

    always begin
        @(negedge clk);
        #2;
        if (gcd_start === 1'b1) start_cnt++;
        if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1 && rsp_n < 64) begin
            rsp_res[rsp_n] = bus.rsp_result;
            rsp_to[rsp_n]  = bus.rsp_timeout;
            rsp_n++;
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eng_run    <= 1'b0;
            eng_cnt    <= 0;
            eng_res    <= '0;
            gcd_done   <= 1'b0;
            gcd_result <= '0;
        end else begin
            gcd_done <= 1'b0;
            if (gcd_start) begin
                eng_run <= (start_cnt != eng_hang_id);
                eng_cnt <= 1;
                eng_res <= gcd_ref(gcd_a, gcd_b);
                if (eng_stale) begin
                    gcd_done   <= 1'b1;
                    gcd_result <= 32'h0000_0BAD;
                end
            end else if (eng_run) begin
                if (eng_cnt >= eng_lat) begin
                    gcd_done   <= 1'b1;
                    gcd_result <= eng_res;
                    eng_run    <= 1'b0;
                end
                eng_cnt <= eng_cnt + 1;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the push was taken.
    task automatic push(input logic [31:0] a, input logic [31:0] b);
        bit ok;
        ok = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (bus.req_ready) ok = 1'b1;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL push_accept: req_ready stayed 0, expected 1");
        end
    endtask

    task automatic wait_rsp(input int target, input int budget);
        int i;
        i = 0;
        while (rsp_n < target && i < budget) begin
            @(negedge clk);
            #3;
            i++;
        end
        @(negedge clk);
        if (rsp_n < target) begin
            checks++;
            errors++;
            $display("FAIL wait_rsp: got %0d responses expected %0d", rsp_n, target);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        bit          stale;
        bit          hang;
        logic [31:0] exp_res;
        bit          exp_to;
        int          exp_starts;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, r0, n;
        bit stable;

        vecs[0]  = '{32'd48,        32'd18,     10, 1'b0, 1'b0, 32'd6,     1'b0, 1};
        vecs[1]  = '{32'd0,         32'd35,     1,  1'b0, 1'b0, 32'd35,    1'b0, 0};
        vecs[2]  = '{32'd0,         32'd0,      1,  1'b0, 1'b0, 32'd0,     1'b0, 0};
        vecs[3]  = '{32'd35,        32'd0,      1,  1'b0, 1'b0, 32'd35,    1'b0, 0};
        vecs[4]  = '{32'd17,        32'd5,      3,  1'b0, 1'b0, 32'd1,     1'b0, 1};
        vecs[5]  = '{32'd100,       32'd75,     5,  1'b1, 1'b0, 32'd25,    1'b0, 1};
        vecs[6]  = '{32'd12,        32'd12,     1,  1'b0, 1'b0, 32'd12,    1'b0, 1};
        vecs[7]  = '{32'hFFFF_FFFF, 32'hFFFF,   2,  1'b0, 1'b0, 32'd65535, 1'b0, 1};
        vecs[8]  = '{32'd9,         32'd6,      4,  1'b0, 1'b1, 32'd0,     1'b1, 1};
        vecs[9]  = '{32'd30,        32'd12,     15, 1'b0, 1'b0, 32'd6,     1'b0, 1};
        vecs[10] = '{32'd30,        32'd12,     16, 1'b0, 1'b0, 32'd0,     1'b1, 1};

        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_req_ready",   32'(bus.req_ready),   32'd1);
        chk("rst_rsp_valid",   32'(bus.rsp_valid),   32'd0);
        chk("rst_gcd_start",   32'(gcd_start),       32'd0);
        chk("rst_busy",        32'(busy),            32'd0);
        chk("rst_rsp_result",  bus.rsp_result,       32'd0);
        chk("rst_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
        chk("rst_gcd_a",       gcd_a,                32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b1;

        // table-driven single jobs
        for (int k = 0; k < NV; k++) begin
            eng_lat     = vecs[k].lat;
            eng_stale   = vecs[k].stale;
            eng_hang_id = vecs[k].hang ? start_cnt + 1 : -1;
            s0 = start_cnt;
            r0 = rsp_n;
            push(vecs[k].a, vecs[k].b);
            wait_rsp(r0 + 1, 60);
            chk($sformatf("vec%0d_result", k),  rsp_res[r0],        vecs[k].exp_res);
            chk($sformatf("vec%0d_timeout", k), 32'(rsp_to[r0]),    32'(vecs[k].exp_to));
            chk($sformatf("vec%0d_starts", k),  32'(start_cnt - s0), 32'(vecs[k].exp_starts));
        end
        eng_stale   = 1'b0;
        eng_hang_id = -1;

        // issue latency: push at N, start pulse at N+2 only
        eng_lat = 3;
        r0 = rsp_n;
        push(32'd48, 32'd18);
        chk("lat_n1_start", 32'(gcd_start), 32'd0);
        chk("lat_n1_busy",  32'(busy),      32'd1);
        @(negedge clk);
        chk("lat_n2_start", 32'(gcd_start), 32'd1);
        chk("lat_n2_gcd_a", gcd_a,          32'd48);
        chk("lat_n2_gcd_b", gcd_b,          32'd18);
        @(negedge clk);
        chk("lat_n3_start", 32'(gcd_start), 32'd0);
        wait_rsp(r0 + 1, 60);
        chk("lat_result", rsp_res[r0], 32'd6);

        // zero-operand latency: response valid at N+2
        r0 = rsp_n;
        push(32'd0, 32'd7);
        chk("zero_n1_valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        chk("zero_n2_valid",  32'(bus.rsp_valid), 32'd1);
        chk("zero_n2_result", bus.rsp_result,     32'd7);
        wait_rsp(r0 + 1, 20);

        // five back-to-back jobs against a slow engine, FIFO fills
        eng_lat = 12;
        r0 = rsp_n;
        push(32'd48, 32'd18);
        push(32'd21, 32'd14);
        push(32'd0,  32'd9);
        push(32'd81, 32'd27);
        chk("fill4_ready", 32'(bus.req_ready), 32'd1);
        push(32'd13, 32'd7);
        chk("full_ready", 32'(bus.req_ready), 32'd0);
        chk("full_busy",  32'(busy),          32'd1);
        // offer a sixth job while full; it must not be taken
        bus.req_valid = 1'b1;
        bus.req_a     = 32'd99;
        bus.req_b     = 32'd33;
        stable = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.req_ready !== 1'b0) stable = 1'b0;
        end
        bus.req_valid = 1'b0;
        chk("full_hold_ready_low", 32'(stable), 32'd1);
        wait_rsp(r0 + 5, 300);
        chk("b2b_res0", rsp_res[r0],     32'd6);
        chk("b2b_res1", rsp_res[r0 + 1], 32'd7);
        chk("b2b_res2", rsp_res[r0 + 2], 32'd9);
        chk("b2b_res3", rsp_res[r0 + 3], 32'd27);
        chk("b2b_res4", rsp_res[r0 + 4], 32'd1);
        repeat (40) @(negedge clk);
        chk("b2b_count", 32'(rsp_n - r0), 32'd5);

        // hung engine: 16 WAIT cycles then timeout, next job proceeds
        eng_lat       = 4;
        bus.rsp_ready = 1'b0;
        eng_hang_id   = start_cnt + 1;
        r0 = rsp_n;
        push(32'd9,  32'd6);
        push(32'd20, 32'd8);
        chk("to_start_seen", 32'(gcd_start), 32'd1);
        n = 0;
        while (!bus.rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("to_cycles",  32'(n),                32'd17);
        chk("to_result",  bus.rsp_result,        32'd0);
        chk("to_flag",    32'(bus.rsp_timeout),  32'd1);
        bus.rsp_ready = 1'b1;
        wait_rsp(r0 + 2, 60);
        eng_hang_id = -1;
        chk("to_next_result",  rsp_res[r0 + 1],      32'd4);
        chk("to_next_timeout", 32'(rsp_to[r0 + 1]),  32'd0);

        // response back-pressure: held stable, no new start
        bus.rsp_ready = 1'b0;
        r0 = rsp_n;
        push(32'd48, 32'd18);
        push(32'd27, 32'd9);
        n = 0;
        while (!bus.rsp_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
        s0 = start_cnt;
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'd6 || bus.rsp_timeout !== 1'b0)
                stable = 1'b0;
        end
        chk("hold_stable", 32'(stable),          32'd1);
        chk("hold_starts", 32'(start_cnt - s0),  32'd0);
        chk("hold_gcd_a",  gcd_a,                32'd48);
        bus.rsp_ready = 1'b1;
        wait_rsp(r0 + 2, 80);
        chk("hold_res0", rsp_res[r0],     32'd6);
        chk("hold_res1", rsp_res[r0 + 1], 32'd9);

        // reset in WAIT with two jobs queued
        eng_hang_id = start_cnt + 1;
        push(32'd9,  32'd6);
        push(32'd10, 32'd4);
        push(32'd14, 32'd21);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy",      32'(busy),          32'd0);
        chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_rst_gcd_start", 32'(gcd_start),     32'd0);
        chk("mid_rst_gcd_a",     gcd_a,              32'd0);
        r0 = rsp_n;
        s0 = start_cnt;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        eng_hang_id = -1;
        chk("post_rst_rsps",   32'(rsp_n - r0),     32'd0);
        chk("post_rst_starts", 32'(start_cnt - s0), 32'd0);
        chk("post_rst_busy",   32'(busy),           32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
